// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: frame-shadowed hex value, one digit lit per REFRESH_DIV-cycle slot.
// Outputs registered one cycle behind scan state; load is always accepted (no backpressure), new data applies at frame boundary.
module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      lz_en,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] act_value;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;
  logic                    frame_bnd_q;

  logic                    slot_end;
  logic                    frame_bnd;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    suppress;
  logic                    dark;
  logic [6:0]              seg_low;
  logic                    dp_low;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg_low(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'b1000000;
      4'h1: pat = 7'b1111001;
      4'h2: pat = 7'b0100100;
      4'h3: pat = 7'b0110000;
      4'h4: pat = 7'b0011001;
      4'h5: pat = 7'b0010010;
      4'h6: pat = 7'b0000010;
      4'h7: pat = 7'b1111000;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0010000;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b0000011;
      4'hC: pat = 7'b1000110;
      4'hD: pat = 7'b0100001;
      4'hE: pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  assign slot_end  = (div_q == DIV_LAST);
  assign frame_bnd = slot_end && (idx_q == IDX_LAST);
  assign cur_nib   = act_value[{idx_q, 2'b00} +: 4];

  // upper_zero[k]: every nibble from digit k up to the top digit is zero.
  always_comb begin
    logic z;
    upper_zero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      z = 1'b1;
      for (int j = k; j < NUM_DIGITS; j++)
        z = z && (act_value[4*j +: 4] == 4'h0);
      upper_zero[k] = z;
    end
  end

  assign suppress = lz_en && (idx_q != '0) && upper_zero[idx_q];
  assign dark     = act_blank[idx_q] || suppress;
  assign seg_low  = dark ? 7'h7F : hex_to_seg_low(cur_nib);
  assign dp_low   = dark ? 1'b1  : ~act_dp[idx_q];

  always_comb begin
    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;
  end

  assign seg_next = SEG_ACTIVE_LOW ? seg_low : ~seg_low;
  assign dp_next  = SEG_ACTIVE_LOW ? dp_low  : ~dp_low;
  assign an_next  = AN_ACTIVE_LOW  ? ~an_onehot : an_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      idx_q       <= '0;
      pend_value  <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_valid  <= 1'b0;
      act_value   <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      frame_bnd_q <= 1'b0;
      frame_done  <= 1'b0;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
      an          <= AN_OFF;
    end else begin
      if (slot_end) begin
        div_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end

      if (frame_bnd && pend_valid) begin
        act_value  <= pend_value;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        pend_valid <= 1'b0;
      end
      // A load on the boundary cycle refills pending after the old contents moved to active.
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end

      // Two stages so the pulse lines up with an switching to digit 0.
      frame_bnd_q <= frame_bnd;
      frame_done  <= frame_bnd_q;
      seg         <= seg_next;
      dp          <= dp_next;
      an          <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux with a time-based reference model of the scan and shadow rules.
module tb_seg7_scan_mux;
  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg7_scan_mux #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .load(load), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_chk = 0;
  int n_pass = 0;

  // Model state: elapsed non-reset cycles plus shown/pending frame contents.
  int          m_cyc = 0;
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_dp = '0, m_bl = '0, p_dp = '0, p_bl = '0;
  bit          p_v = 0;
  bit          m_bnd = 0;

  logic [6:0]  seen [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Called just after a falling edge: predicts outputs of the preceding rising edge, then advances the model.
  task automatic step_check();
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_fd;
    logic [3:0] nib;
    int         k;
    bit         dk;
    if (reset) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
      m_cyc = 0; m_val = '0; m_dp = '0; m_bl = '0;
      p_val = '0; p_dp = '0; p_bl = '0; p_v = 0; m_bnd = 0;
    end else begin
      k     = (m_cyc / R) % N;
      nib   = m_val[4*k +: 4];
      dk    = m_bl[k] || (lz_en && k > 0 && (m_val >> (4*k)) == 16'h0);
      e_an  = ~(4'b0001 << k);
      e_seg = dk ? 7'b1111111 : seg_tab[nib];
      e_dp  = dk ? 1'b1 : ~m_dp[k];
      e_fd  = m_bnd;
      m_bnd = (m_cyc % (N*R)) == (N*R - 1);
      if (m_bnd && p_v) begin
        m_val = p_val; m_dp = p_dp; m_bl = p_bl; p_v = 0;
      end
      if (load) begin
        p_val = value; p_dp = dp_in; p_bl = blank_in; p_v = 1;
      end
      m_cyc++;
    end
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic tick();
    @(negedge clk);
    step_check();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    repeat (2*N*R) tick();

    // Leading-zero case: value 0x0050 shown as "  50".
    value = 16'h0050; lz_en = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3*N*R) tick();
    for (int i = 0; i < 4; i++) seen[i] = '0;
    for (int c = 0; c < N*R; c++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (an == ~(4'b0001 << i)) seen[i] = seg;
    end
    chk("lz_digit3", 32'(seen[3]), 32'(7'b1111111));
    chk("lz_digit2", 32'(seen[2]), 32'(7'b1111111));
    chk("lz_digit1", 32'(seen[1]), 32'(7'b0010010));
    chk("lz_digit0", 32'(seen[0]), 32'(7'b1000000));

    // Random phase: loads, blanking, dp, live lz_en changes and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      load     = ($urandom_range(0, 19) == 0);
      value    = 16'($urandom >> (4 * $urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) value = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 30) == 0) lz_en = ~lz_en;
      reset    = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    load  = 1'b0;
    repeat (2*N*R) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Parametrised, time-multiplexed driver for a common-anode/cathode multi-digit 7-segment display bank. It holds a packed hex value in a frame-synchronised shadow register and scans one digit per refresh slot. Each slot drives that digit's anode and decoded segments, with per-digit decimal point, forced blanking and optional leading-zero suppression. It sits between the processor's debug/IO register (PC, ALU result, register-file tap) and the board's display pins, replacing per-digit combinational decoders.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2)
- SEG_ACTIVE_LOW, 1, 1 = seg/dp pins lit at 0
- AN_ACTIVE_LOW, 1, 1 = anode pins enabled at 0

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- value  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 = least significant
- dp_in  in  NUM_DIGITS  decimal point per digit
- blank_in  in  NUM_DIGITS  force digit k dark (segments and dp)
- lz_en  in  1  enable leading-zero suppression
- load  in  1  capture value/dp_in/blank_in into pending register
- seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
- an  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse when the last digit slot ends

## Operation
- Registers:
  - div counter, 0..REFRESH_DIV-1
  - digit index idx, 0..NUM_DIGITS-1
  - pending {value, dp, blank} plus pend_valid
  - active {value, dp, blank}
  - registered outputs
- Load: `load`=1 → pending <= inputs, pend_valid <= 1. Active contents never change mid-frame.
- Frame boundary: cycle where div==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
  - If pend_valid: active <= pending, pend_valid <= 0.
  - If load is also asserted that cycle: pending <= new inputs, active <= old pending, pend_valid stays 1. The new data applies at the next boundary.
- Scan: each cycle div increments. At REFRESH_DIV-1, div wraps to 0 and idx increments; idx wraps NUM_DIGITS-1 → 0.
- Decode of the active nibble, active-low form (bit order g..a), 0..F:
  - 0–7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000
  - 8–F: 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110
  - When SEG_ACTIVE_LOW=0, seg and dp are the bitwise inverse.
- Digit k is dark (all segments off, dp off) if either:
  - active blank[k]=1, or
  - lz_en=1, k>0, and nibbles k..NUM_DIGITS-1 are all zero.
- Digit 0 is never zero-suppressed.
- dp for a non-dark digit = active dp[k].
- an: only bit idx enabled; all others disabled. Polarity per AN_ACTIVE_LOW. A dark digit still has its anode enabled.

## Timing
- Reset values (outputs):
  - an = all disabled
  - seg = all off
  - dp = off
  - frame_done = 0
- Reset values (internal):
  - div = 0, idx = 0
  - active = all zero, blank = 0, dp = 0
  - pending cleared, pend_valid = 0
- Output latency: seg/dp/an are registered and reflect the idx and active state of the previous cycle. The first cycle after reset deasserts drives digit 0 showing "0".
- Slot length: each digit is lit for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- frame_done is registered and high for the one cycle after the frame boundary, i.e. coincident with an switching to digit 0.
- Value latency: data captured by load appears on seg in the first digit-0 slot after the next frame boundary, at most one frame plus one cycle later.
- Reset mid-frame: all state returns to reset values on the next edge; pending data is discarded.
- lz_en is sampled live (not shadowed) and may change suppression mid-frame.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, both polarities active-low.
- **Reset/idle:** hold reset 3 cycles, release.
  - During reset: an=1111, seg=1111111, dp=1.
  - Next cycle: an=1110, seg=1000000.
  - Anodes then advance every 4 cycles: 1101, 1011, 0111.
  - frame_done pulses every 16 cycles.
- **Full decode:** load 0x0123, then 0x4567, 0x89AB, 0xCDEF, one per frame.
  - Each digit's seg matches the table for its nibble; E=0000110.
- **Shadowing:** load 0x1234 at the 2nd cycle of digit 1.
  - The remainder of the frame still shows the old value.
  - 0x1234 appears from the next digit-0 slot.
  - Load coinciding with the boundary cycle follows the boundary rule.
- **Leading zeros:** value=0x0050, lz_en=1.
  - Digits 3 and 2 show seg=1111111; digit 1 shows 0010010; digit 0 shows 1000000.
  - value=0x0000 shows only digit 0 lit.
- **Blank/dp:** blank_in=0100, dp_in=0011, value=0x1111.
  - Digit 2 is fully dark.
  - Digits 0 and 1 show dp=0; digit 3 shows dp=1.
- **Reset mid-operation:** assert reset during digit 2 with pend_valid=1.
  - Outputs go to reset values.
  - After release, digit 0 shows "0"; pending data is never displayed.
